general_bring_up_tx: RTL and testbench
======================================

GENERAL_BRING_UP_TX -- requirements
Module: general_bring_up_tx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning WAIT_RSP cycles before timeout, legal range 2..65535.
REQ-002 SHALL have port lclk  in  1  clock; all logic rises on posedge.
REQ-003 SHALL have port sys_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rdi_controller_choosen_bring_up  in  3  bring-up code: 1 ACTIVE, 2 RETRAIN, 3 LINKERROR, 4 LINKRESET, 5 DISABLE; 0/6/7 none.
REQ-005 SHALL have port i_rx_sb_message  in  4  message received from the link partner.
REQ-006 SHALL have port i_rx_msg_valid  in  1  qualifies i_rx_sb_message for one cycle.
REQ-007 SHALL have port i_tx_done_send_message  in  1  sideband TX has finished sending the current message.
REQ-008 SHALL have port i_tx_busy_from_RX  in  1  RX responder currently owns sideband TX.
REQ-009 SHALL have port o_tx_sb_message  out  4  request encoding to sideband TX.
REQ-010 SHALL have port o_tx_msg_valid  out  1  o_tx_sb_message valid.
REQ-011 SHALL have port o_tx_busy_to_RX  out  1  high while this block owns sideband TX.
REQ-012 SHALL have port o_General_Bring_Up_done_TX  out  1  matching response received.
REQ-013 SHALL have port o_timeout_error  out  1  no response within TIMEOUT_CYCLES.

Function
REQ-014 SHALL implement FSM states IDLE, REQ_SEND, WAIT_RSP, DONE, ERROR; all outputs registered, decoded from next state.
REQ-015 SHALL go IDLE->REQ_SEND when the code is 1..5 and i_tx_busy_from_RX=0; codes 0/6/7 or busy keep IDLE.
REQ-016 SHALL latch the code at IDLE->REQ_SEND; code changes after that do not alter the message sent.
REQ-017 SHALL map latched code 1/2/3/4/5 to ACTIVE_REQ=1 / RETRAIN_REQ=11 / LINKERROR_REQ=9 / LINKRESET_REQ=7 / DISABLE_REQ=13; expected response is request+1.
REQ-018 SHALL hold o_tx_msg_valid=1, o_tx_sb_message stable and o_tx_busy_to_RX=1 for every REQ_SEND cycle, starting the cycle after entry decision.
REQ-019 SHALL leave REQ_SEND on i_tx_done_send_message: to DONE if a matching response is also valid that cycle, else to WAIT_RSP; valid and busy drop the following cycle.
REQ-020 SHALL in WAIT_RSP go to DONE on i_rx_msg_valid with i_rx_sb_message equal to expected response; any other message, including partner requests, is ignored.
REQ-021 SHALL hold o_General_Bring_Up_done_TX=1 in DONE until code==0, then return to IDLE.
REQ-022 SHALL abort WAIT_RSP to IDLE when code becomes 0; REQ_SEND is never aborted by code change.
REQ-023 SHALL count WAIT_RSP cycles from 0, clear on WAIT_RSP entry, and move to ERROR on count TIMEOUT_CYCLES-1 (see REQ-027).
REQ-024 SHALL give a matching response priority over timeout expiry in the same cycle.
REQ-025 SHALL hold o_timeout_error=1 in ERROR until code==0, then return to IDLE.

Reset
REQ-026 SHALL on sys_rst low, immediately and at any state, force IDLE, counter 0, latched code 0, all outputs 0, including mid-REQ_SEND.

Configuration
REQ-027 SHALL, with GBU_TX_TIMEOUT_EN defined, include the counter, ERROR state and REQ-023..025; without it, WAIT_RSP waits indefinitely, ERROR is unreachable and o_timeout_error is tied 0.

Structure
REQ-028 SHALL take sideband message encodings, bring-up code values and FSM state encodings from shared package rdi_sb_pkg, also used by the RX responder.
REQ-029 SHALL place the timeout counter in sub-module gbu_rsp_timer (inputs clear, enable; output expired), instantiated only under GBU_TX_TIMEOUT_EN.

Verification
REQ-030 SHALL check: code=1, done_send after 3 cycles, RSP=2 valid 5 cycles later -> message 1 valid 3 cycles, done_TX=1 until code=0, then IDLE.
REQ-031 SHALL check: code=4 with i_tx_busy_from_RX=1 for 10 cycles -> no valid until busy drops, then message 7 sent.
REQ-032 SHALL check: code=2, response 10 (wrong) then 12 -> 10 ignored, done_TX after 12.
REQ-033 SHALL check (TIMEOUT_CYCLES=8, macro on): code=5, no response -> o_timeout_error=1 exactly 8 cycles after WAIT_RSP entry; response 14 on expiry cycle -> done_TX instead.
REQ-034 SHALL check: code=3 dropped to 0 during WAIT_RSP -> IDLE, no done, no error; sys_rst low mid-REQ_SEND -> all outputs 0 asynchronously.
REQ-035 SHALL check: macro off, code=1, no response for 70000 cycles -> stays WAIT_RSP, o_timeout_error=0.

Source files
------------

// File: rtl/rdi_sb_pkg.sv
// Shared sideband definitions for the RDI bring-up TX requester and RX responder:
// message encodings, bring-up code values, FSM state encoding and the
// code-to-request mapping helper.
package rdi_sb_pkg;

  // Bring-up codes presented by the RDI controller
  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_ACTIVE    = 3'd1;
  localparam logic [2:0] CODE_RETRAIN   = 3'd2;
  localparam logic [2:0] CODE_LINKERROR = 3'd3;
  localparam logic [2:0] CODE_LINKRESET = 3'd4;
  localparam logic [2:0] CODE_DISABLE   = 3'd5;

  // Sideband message encodings; every response is its request plus one
  localparam logic [3:0] SB_NOP           = 4'd0;
  localparam logic [3:0] SB_ACTIVE_REQ    = 4'd1;
  localparam logic [3:0] SB_ACTIVE_RSP    = 4'd2;
  localparam logic [3:0] SB_LINKRESET_REQ = 4'd7;
  localparam logic [3:0] SB_LINKRESET_RSP = 4'd8;
  localparam logic [3:0] SB_LINKERROR_REQ = 4'd9;
  localparam logic [3:0] SB_LINKERROR_RSP = 4'd10;
  localparam logic [3:0] SB_RETRAIN_REQ   = 4'd11;
  localparam logic [3:0] SB_RETRAIN_RSP   = 4'd12;
  localparam logic [3:0] SB_DISABLE_REQ   = 4'd13;
  localparam logic [3:0] SB_DISABLE_RSP   = 4'd14;

  // Bring-up requester state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_SEND = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } gbu_state_e;

  // True for codes that actually request a bring-up action
  function automatic logic code_is_request(input logic [2:0] code);
    return (code >= CODE_ACTIVE) && (code <= CODE_DISABLE);
  endfunction

  // Request message for a bring-up code; NOP for codes with no action
  function automatic logic [3:0] req_for_code(input logic [2:0] code);
    logic [3:0] msg;
    case (code)
      CODE_ACTIVE:    msg = SB_ACTIVE_REQ;
      CODE_RETRAIN:   msg = SB_RETRAIN_REQ;
      CODE_LINKERROR: msg = SB_LINKERROR_REQ;
      CODE_LINKRESET: msg = SB_LINKRESET_REQ;
      CODE_DISABLE:   msg = SB_DISABLE_REQ;
      default:        msg = SB_NOP;
    endcase
    return msg;
  endfunction

endpackage

// File: rtl/gbu_rsp_timer.sv
// Response timer for the bring-up requester. Counts cycles while enabled,
// saturating at the last count; expired is high while enabled on the final
// cycle (count == TIMEOUT_CYCLES-1). Instantiated only with GBU_TX_TIMEOUT_EN.
module gbu_rsp_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic lclk,
  input  logic sys_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_reg;

  // Cycle counter: cleared outside the wait window, saturates at the last count
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST_COUNT)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/general_bring_up_tx.sv
// General bring-up TX requester: on a bring-up code from the RDI controller it
// claims sideband TX, sends the matching request, then waits for the partner's
// response. All outputs are registered and decoded from the next state.
// Optional response timeout is enabled with the GBU_TX_TIMEOUT_EN macro; without
// it the wait is unbounded and o_timeout_error is tied low.
module general_bring_up_tx
  import rdi_sb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       lclk,
  input  logic       sys_rst,
  input  logic [2:0] i_rdi_controller_choosen_bring_up,
  input  logic [3:0] i_rx_sb_message,
  input  logic       i_rx_msg_valid,
  input  logic       i_tx_done_send_message,
  input  logic       i_tx_busy_from_RX,
  output logic [3:0] o_tx_sb_message,
  output logic       o_tx_msg_valid,
  output logic       o_tx_busy_to_RX,
  output logic       o_General_Bring_Up_done_TX,
  output logic       o_timeout_error
);

  gbu_state_e state_reg;
  gbu_state_e state_next;
  logic [2:0] code_reg;
  logic [2:0] code_next;
  logic [3:0] rsp_expected;
  logic       rsp_match;
  logic       code_cleared;
  logic       timeout_hit;
  logic [3:0] msg_next;

  // The code is sampled once when leaving IDLE; later changes never alter the message
  assign rsp_expected = req_for_code(code_reg) + 4'd1;
  assign rsp_match    = i_rx_msg_valid && (i_rx_sb_message == rsp_expected);
  assign code_cleared = (i_rdi_controller_choosen_bring_up == CODE_NONE);

`ifdef GBU_TX_TIMEOUT_EN
  gbu_rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .lclk   (lclk),
    .sys_rst(sys_rst),
    .clear  (state_reg != ST_WAIT_RSP),
    .enable (state_reg == ST_WAIT_RSP),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State and latched-code registers
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg <= ST_IDLE;
      code_reg  <= CODE_NONE;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
    end
  end

  // Next-state logic; a matching response always wins over timeout expiry
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    case (state_reg)
      ST_IDLE: begin
        if (code_is_request(i_rdi_controller_choosen_bring_up) && !i_tx_busy_from_RX) begin
          state_next = ST_REQ_SEND;
          code_next  = i_rdi_controller_choosen_bring_up;
        end
      end
      ST_REQ_SEND: begin
        if (i_tx_done_send_message) begin
          state_next = rsp_match ? ST_DONE : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_match) begin
          state_next = ST_DONE;
        end else if (code_cleared) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          state_next = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (code_cleared) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (code_cleared) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign msg_next = (state_next == ST_REQ_SEND) ? req_for_code(code_next) : SB_NOP;

  // Registered outputs decoded from the next state
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      o_tx_sb_message            <= SB_NOP;
      o_tx_msg_valid             <= 1'b0;
      o_tx_busy_to_RX            <= 1'b0;
      o_General_Bring_Up_done_TX <= 1'b0;
    end else begin
      o_tx_sb_message            <= msg_next;
      o_tx_msg_valid             <= (state_next == ST_REQ_SEND);
      o_tx_busy_to_RX            <= (state_next == ST_REQ_SEND);
      o_General_Bring_Up_done_TX <= (state_next == ST_DONE);
    end
  end

`ifdef GBU_TX_TIMEOUT_EN
  // Timeout flag held for as long as the requester sits in ERROR
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      o_timeout_error <= 1'b0;
    end else begin
      o_timeout_error <= (state_next == ST_ERROR);
    end
  end
`else
  assign o_timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_general_bring_up_tx.sv
// Directed bench for general_bring_up_tx: a cycle-by-cycle vector table for the
// basic handshakes plus hand-written sequences for busy hold-off, abort, async
// reset and the GBU_TX_TIMEOUT_EN-dependent timeout behaviour.
module tb_general_bring_up_tx;

  logic       lclk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [2:0] code = 3'd0;
  logic [3:0] rx_msg = 4'd0;
  logic       rx_valid = 1'b0;
  logic       done_send = 1'b0;
  logic       busy_rx = 1'b0;
  logic [3:0] tx_msg;
  logic       tx_valid;
  logic       tx_busy;
  logic       bu_done;
  logic       tmo_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] code;
    logic       busy;
    logic       done_send;
    logic       rx_valid;
    logic [3:0] rx_msg;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  general_bring_up_tx #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .lclk                             (lclk),
    .sys_rst                          (sys_rst),
    .i_rdi_controller_choosen_bring_up(code),
    .i_rx_sb_message                  (rx_msg),
    .i_rx_msg_valid                   (rx_valid),
    .i_tx_done_send_message           (done_send),
    .i_tx_busy_from_RX                (busy_rx),
    .o_tx_sb_message                  (tx_msg),
    .o_tx_msg_valid                   (tx_valid),
    .o_tx_busy_to_RX                  (tx_busy),
    .o_General_Bring_Up_done_TX       (bu_done),
    .o_timeout_error                  (tmo_err)
  );

  always #5 lclk = ~lclk;

  // Expected output word: {valid, msg[3:0], busy, done, error}
  function automatic logic [7:0] ex(input logic v, input logic [3:0] m, input logic b,
                                    input logic d, input logic e);
    return {v, m, b, d, e};
  endfunction

  function automatic vec_t mk(input logic [2:0] c, input logic bz, input logic ds,
                              input logic rv, input logic [3:0] rm, input logic [7:0] e);
    vec_t v;
    v.code = c; v.busy = bz; v.done_send = ds; v.rx_valid = rv; v.rx_msg = rm; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic [2:0] c, input logic bz, input logic ds,
                       input logic rv, input logic [3:0] rm);
    code = c; busy_rx = bz; done_send = ds; rx_valid = rv; rx_msg = rm;
  endtask

  task automatic step();
    @(posedge lclk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {tx_valid, tx_msg, tx_busy, bu_done, tmo_err};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got valid=%0b msg=%0d busy=%0b done=%0b err=%0b, required valid=%0b msg=%0d busy=%0b done=%0b err=%0b",
               name, act[7], act[6:3], act[2], act[1], act[0],
               exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: valid=%0b msg=%0d busy=%0b done=%0b err=%0b",
               name, act[7], act[6:3], act[2], act[1], act[0]);
    end
  endtask

  initial begin
    logic [7:0] zero;
    logic       bad;
    zero = 8'h00;

    // Code 1: three REQ_SEND cycles, response 2 five cycles after done_send
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, ex(1, 4'd1, 1, 0, 0)));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, ex(1, 4'd1, 1, 0, 0)));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, ex(1, 4'd1, 1, 0, 0)));
    vecs.push_back(mk(3'd1, 0, 1, 0, 4'd0, zero));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, zero));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, zero));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, zero));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, zero));
    vecs.push_back(mk(3'd1, 0, 0, 1, 4'd2, ex(0, 4'd0, 0, 1, 0)));
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, ex(0, 4'd0, 0, 1, 0)));
    vecs.push_back(mk(3'd3, 0, 0, 0, 4'd0, ex(0, 4'd0, 0, 1, 0)));
    vecs.push_back(mk(3'd0, 0, 0, 0, 4'd0, zero));
    // Codes 6 and 7 never start a request
    vecs.push_back(mk(3'd6, 0, 0, 0, 4'd0, zero));
    vecs.push_back(mk(3'd7, 0, 0, 0, 4'd0, zero));
    // Code 2: code changes in REQ_SEND ignored; wrong rsp 10 and partner req 11 ignored
    vecs.push_back(mk(3'd2, 0, 0, 0, 4'd0, ex(1, 4'd11, 1, 0, 0)));
    vecs.push_back(mk(3'd5, 0, 0, 0, 4'd0, ex(1, 4'd11, 1, 0, 0)));
    vecs.push_back(mk(3'd2, 0, 1, 0, 4'd0, zero));
    vecs.push_back(mk(3'd2, 0, 0, 1, 4'd10, zero));
    vecs.push_back(mk(3'd2, 0, 0, 1, 4'd11, zero));
    vecs.push_back(mk(3'd2, 0, 0, 1, 4'd12, ex(0, 4'd0, 0, 1, 0)));
    vecs.push_back(mk(3'd0, 0, 0, 0, 4'd0, zero));
    // Code 1: response matching in the same cycle as done_send goes straight to DONE
    vecs.push_back(mk(3'd1, 0, 0, 0, 4'd0, ex(1, 4'd1, 1, 0, 0)));
    vecs.push_back(mk(3'd1, 0, 1, 1, 4'd2, ex(0, 4'd0, 0, 1, 0)));
    vecs.push_back(mk(3'd0, 0, 0, 0, 4'd0, zero));
    // Code 5: REQ_SEND not left without done_send even if code drops to 0
    vecs.push_back(mk(3'd5, 0, 0, 0, 4'd0, ex(1, 4'd13, 1, 0, 0)));
    vecs.push_back(mk(3'd0, 0, 0, 0, 4'd0, ex(1, 4'd13, 1, 0, 0)));
    vecs.push_back(mk(3'd0, 0, 1, 0, 4'd0, zero));
    vecs.push_back(mk(3'd0, 0, 0, 0, 4'd0, zero));

    // Reset, outputs low during reset and after release
    drive(3'd0, 0, 0, 0, 4'd0);
    repeat (3) @(posedge lclk);
    #1;
    check("reset_hold", zero);
    sys_rst = 1'b1;
    step();
    check("reset_release", zero);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].code, vecs[i].busy, vecs[i].done_send, vecs[i].rx_valid, vecs[i].rx_msg);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Code 4 held off by RX owning sideband TX for 10 cycles
    for (int i = 0; i < 10; i++) begin
      drive(3'd4, 1, 0, 0, 4'd0);
      step();
      check($sformatf("busy_hold%0d", i), zero);
    end
    drive(3'd4, 0, 0, 0, 4'd0);
    step();
    check("busy_release_send", ex(1, 4'd7, 1, 0, 0));
    drive(3'd4, 0, 1, 0, 4'd0);
    step();
    check("linkreset_wait", zero);
    drive(3'd4, 0, 0, 1, 4'd8);
    step();
    check("linkreset_done", ex(0, 4'd0, 0, 1, 0));
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    check("linkreset_idle", zero);

    // Code 3 aborted in WAIT_RSP by code dropping to 0
    drive(3'd3, 0, 0, 0, 4'd0);
    step();
    check("abort_send", ex(1, 4'd9, 1, 0, 0));
    drive(3'd3, 0, 1, 0, 4'd0);
    step();
    check("abort_wait", zero);
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    check("abort_idle", zero);
    drive(3'd0, 0, 0, 1, 4'd10);
    step();
    check("abort_late_rsp", zero);
    for (int i = 0; i < 10; i++) step();
    check("abort_quiet", zero);

    // Asynchronous reset in the middle of REQ_SEND
    drive(3'd1, 0, 0, 0, 4'd0);
    step();
    check("rst_pre_send", ex(1, 4'd1, 1, 0, 0));
    #2;
    sys_rst = 1'b0;
    #1;
    check("rst_async", zero);
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    sys_rst = 1'b1;
    step();
    check("rst_after_release", zero);

`ifdef GBU_TX_TIMEOUT_EN
    // Code 5 with no response: error exactly 8 cycles after WAIT_RSP entry
    drive(3'd5, 0, 0, 0, 4'd0);
    step();
    check("tmo_send", ex(1, 4'd13, 1, 0, 0));
    drive(3'd5, 0, 1, 0, 4'd0);
    step();
    check("tmo_wait_entry", zero);
    drive(3'd5, 0, 0, 0, 4'd0);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("tmo_wait%0d", k), zero);
    end
    step();
    check("tmo_error", ex(0, 4'd0, 0, 0, 1));
    step();
    check("tmo_error_hold", ex(0, 4'd0, 0, 0, 1));
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    check("tmo_error_clear", zero);

    // Matching response on the expiry cycle wins
    drive(3'd5, 0, 0, 0, 4'd0);
    step();
    check("tmo2_send", ex(1, 4'd13, 1, 0, 0));
    drive(3'd5, 0, 1, 0, 4'd0);
    step();
    drive(3'd5, 0, 0, 0, 4'd0);
    for (int k = 1; k < 8; k++) step();
    check("tmo2_pre_expiry", zero);
    drive(3'd5, 0, 0, 1, 4'd14);
    step();
    check("tmo2_rsp_wins", ex(0, 4'd0, 0, 1, 0));
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    check("tmo2_idle", zero);
`else
    // No timeout: 70000 cycles of silence keep the requester waiting
    drive(3'd1, 0, 0, 0, 4'd0);
    step();
    check("long_send", ex(1, 4'd1, 1, 0, 0));
    drive(3'd1, 0, 1, 0, 4'd0);
    step();
    drive(3'd1, 0, 0, 0, 4'd0);
    bad = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if ({tx_valid, tx_msg, tx_busy, bu_done, tmo_err} !== zero) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL long_wait_quiet: got outputs active during wait, required all 0");
    end else begin
      $display("ok   long_wait_quiet: outputs 0 for 70000 cycles");
    end
    drive(3'd1, 0, 0, 1, 4'd2);
    step();
    check("long_wait_still_waiting", ex(0, 4'd0, 0, 1, 0));
    drive(3'd0, 0, 0, 0, 4'd0);
    step();
    check("long_idle", zero);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
